imem_responder: RTL and testbench

Instruction-memory responder that serves fetch requests from the instruction-fetch unit over a valid/ready request/response handshake, with configurable wait states. It holds the instruction store, checks alignment and range, supports program loading through a write port, and discards in-flight fetches on a PC redirect. It sits between the fetch stage and the instruction store when memory is not instantiated combinationally inside the core.

---
 rtl/imem_responder_pkg.sv | 14 +
 rtl/imem_responder_array.sv | 28 ++
 rtl/imem_responder.sv | 141 ++++++++++++++
 tb/tb_imem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared constants and types for the instruction-memory responder.
package imem_responder_pkg;

   localparam int DEF_PC_WIDTH          = 32;
   localparam int DEF_INSTRUCTION_WIDTH = 32;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

endpackage

// File: rtl/imem_responder_array.sv
// Instruction store: one synchronous write port, one asynchronous read port.
// Because the read is combinational, a read and write to the same word at
// the same edge returns the old contents.
module imem_array #(
   parameter int DEPTH_WORDS       = 1024,
   parameter int INSTRUCTION_WIDTH = 32,
   parameter int IDX_BITS          = $clog2(DEPTH_WORDS)
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [IDX_BITS-1:0]          waddr,
   input  logic [INSTRUCTION_WIDTH-1:0] wdata,
   input  logic [IDX_BITS-1:0]          raddr,
   output logic [INSTRUCTION_WIDTH-1:0] rdata
);

   logic [INSTRUCTION_WIDTH-1:0] mem [DEPTH_WORDS];

   // Program-load write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// Fetch responder: valid/ready request/response handshake in front of the
// instruction store, with a configurable number of wait states, alignment
// and range checking, and flush of in-flight fetches on a PC redirect.
module imem_responder
   import imem_responder_pkg::*;
#(
   parameter int PC_WIDTH          = DEF_PC_WIDTH,
   parameter int INSTRUCTION_WIDTH = DEF_INSTRUCTION_WIDTH,
   parameter int DEPTH_WORDS       = 1024,
   parameter int WAIT_STATES       = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   input  logic [PC_WIDTH-1:0]          req_addr,
   output logic                         req_ready,
   input  logic                         flush,
   output logic                         rsp_valid,
   output logic [INSTRUCTION_WIDTH-1:0] rsp_inst,
   output logic                         rsp_err,
   input  logic                         rsp_ready,
   input  logic                         prog_we,
   input  logic [PC_WIDTH-1:0]          prog_addr,
   input  logic [INSTRUCTION_WIDTH-1:0] prog_wdata
);

   localparam int IDX_BITS = $clog2(DEPTH_WORDS);
   localparam logic ZERO_WAIT = (WAIT_STATES == 0);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
   localparam state_t ACCEPT_STATE = ZERO_WAIT ? ST_RESP : ST_WAIT;
   localparam logic [INSTRUCTION_WIDTH-1:0] NOP = INSTRUCTION_WIDTH'(NOP_INST);

   // An address is unusable if it is not word aligned or its word index
   // falls beyond the end of the store.
   function automatic logic addr_bad(input logic [PC_WIDTH-1:0] a);
      return (a[1:0] != 2'b00) || ((a >> (IDX_BITS + 2)) != '0);
   endfunction

   state_t                       state;
   state_t                       state_next;
   logic [3:0]                   wait_cnt;
   logic [PC_WIDTH-1:0]          addr_q;
   logic                         accept;
   logic                         load_rsp;
   logic [PC_WIDTH-1:0]          rd_addr;
   logic                         rd_err;
   logic [INSTRUCTION_WIDTH-1:0] mem_rdata;
   logic                         prog_ok;

   assign req_ready = !flush && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == ST_RESP);

   // With no wait states the response is loaded at the accept edge, so the
   // read comes straight from the request; otherwise from the latched address.
   assign rd_addr = ZERO_WAIT ? req_addr : addr_q;
   assign rd_err  = addr_bad(rd_addr);
   assign prog_ok = prog_we && !addr_bad(prog_addr);

   imem_array #(
      .DEPTH_WORDS       (DEPTH_WORDS),
      .INSTRUCTION_WIDTH (INSTRUCTION_WIDTH),
      .IDX_BITS          (IDX_BITS)
   ) u_array (
      .clk   (clk),
      .we    (prog_ok),
      .waddr (prog_addr[IDX_BITS+1:2]),
      .wdata (prog_wdata),
      .raddr (rd_addr[IDX_BITS+1:2]),
      .rdata (mem_rdata)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and response-load decision; flush beats everything else.
   always_comb begin
      state_next = state;
      load_rsp   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = ACCEPT_STATE;
               load_rsp   = ZERO_WAIT;
            end
         end
         ST_WAIT: begin
            if (flush) begin
               state_next = ST_IDLE;
            end else if (wait_cnt == 4'd1) begin
               state_next = ST_RESP;
               load_rsp   = 1'b1;
            end
         end
         ST_RESP: begin
            if (flush) begin
               state_next = ST_IDLE;
            end else if (rsp_ready) begin
               if (accept) begin
                  state_next = ACCEPT_STATE;
                  load_rsp   = ZERO_WAIT;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Wait counter and address latch, both loaded on accept.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= 4'd0;
         addr_q   <= '0;
      end else if (accept) begin
         wait_cnt <= WAIT_LOAD;
         addr_q   <= req_addr;
      end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Registered response; bad addresses return a NOP with the error flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsp_inst <= NOP;
         rsp_err  <= 1'b0;
      end else if (load_rsp) begin
         rsp_inst <= rd_err ? NOP : mem_rdata;
         rsp_err  <= rd_err;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: one responder with one wait state, one with none.
module tb_imem_responder;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] I0  = 32'h0050_0093;
   localparam logic [31:0] I1  = 32'h00A0_0113;
   localparam logic [31:0] I2  = 32'h00F0_0193;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        prog_we;
   logic [31:0] prog_addr;
   logic [31:0] prog_wdata;

   logic        req_valid1, req_ready1, rsp_valid1, rsp_err1, rsp_ready1;
   logic [31:0] req_addr1, rsp_inst1;
   logic        req_valid0, req_ready0, rsp_valid0, rsp_err0, rsp_ready0;
   logic [31:0] req_addr0, rsp_inst0;

   int n_cmp = 0;
   int n_err = 0;

   imem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(1)) dut1 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid1), .req_addr(req_addr1), .req_ready(req_ready1),
      .flush(flush),
      .rsp_valid(rsp_valid1), .rsp_inst(rsp_inst1), .rsp_err(rsp_err1), .rsp_ready(rsp_ready1),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
   );

   imem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_addr(req_addr0), .req_ready(req_ready0),
      .flush(1'b0),
      .rsp_valid(rsp_valid0), .rsp_inst(rsp_inst0), .rsp_err(rsp_err0), .rsp_ready(rsp_ready0),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic prog_word(input logic [31:0] a, input logic [31:0] d);
      prog_we = 1'b1; prog_addr = a; prog_wdata = d;
      tick();
      prog_we = 1'b0;
   endtask

   // Overall time guard so the bench can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL timeout: observed running expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      reset = 1'b1; flush = 1'b0;
      prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
      req_valid1 = 1'b0; req_addr1 = '0; rsp_ready1 = 1'b0;
      req_valid0 = 1'b0; req_addr0 = '0; rsp_ready0 = 1'b0;
      #1;
      check_output("reset_valid", 32'(rsp_valid1), 32'd0);
      check_output("reset_inst", rsp_inst1, NOP);
      check_output("reset_err", 32'(rsp_err1), 32'd0);
      check_output("reset_ready", 32'(req_ready1), 32'd1);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      tick();

      // Program three words plus two writes that must be dropped.
      prog_word(32'h0, I0);
      prog_word(32'h4, I1);
      prog_word(32'h8, I2);
      prog_word(32'h6, 32'hDEAD_BEEF);
      prog_word(32'h40, 32'hBAD0_0BAD);

      // Single fetch, one wait state.
      req_valid1 = 1'b1; req_addr1 = 32'h0; rsp_ready1 = 1'b1;
      #1 check_output("ws1_ready_idle", 32'(req_ready1), 32'd1);
      tick();
      req_valid1 = 1'b0;
      #1 check_output("ws1_valid_wait", 32'(rsp_valid1), 32'd0);
      check_output("ws1_ready_wait", 32'(req_ready1), 32'd0);
      tick();
      check_output("ws1_valid_resp", 32'(rsp_valid1), 32'd1);
      check_output("ws1_inst", rsp_inst1, I0);
      check_output("ws1_err", 32'(rsp_err1), 32'd0);
      tick();
      check_output("ws1_valid_idle", 32'(rsp_valid1), 32'd0);

      // Backpressure in RESP with a request waiting.
      req_valid1 = 1'b1; req_addr1 = 32'h4; rsp_ready1 = 1'b0;
      tick();
      req_addr1 = 32'h8;
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         check_output("bp_valid", 32'(rsp_valid1), 32'd1);
         check_output("bp_inst", rsp_inst1, I1);
         check_output("bp_ready", 32'(req_ready1), 32'd0);
         tick();
      end
      req_valid1 = 1'b0; rsp_ready1 = 1'b1;
      #1 check_output("bp_ready_release", 32'(req_ready1), 32'd1);
      check_output("bp_valid_release", 32'(rsp_valid1), 32'd1);
      tick();
      check_output("bp_valid_idle", 32'(rsp_valid1), 32'd0);

      // Misaligned then out-of-range, back to back.
      req_valid1 = 1'b1; req_addr1 = 32'h2;
      tick();
      req_valid1 = 1'b0;
      #1 check_output("mis_valid_wait", 32'(rsp_valid1), 32'd0);
      tick();
      check_output("mis_valid", 32'(rsp_valid1), 32'd1);
      check_output("mis_err", 32'(rsp_err1), 32'd1);
      check_output("mis_inst", rsp_inst1, NOP);
      req_valid1 = 1'b1; req_addr1 = 32'h40;
      #1 check_output("oor_ready_b2b", 32'(req_ready1), 32'd1);
      tick();
      req_valid1 = 1'b0;
      #1 check_output("oor_valid_wait", 32'(rsp_valid1), 32'd0);
      tick();
      check_output("oor_valid", 32'(rsp_valid1), 32'd1);
      check_output("oor_err", 32'(rsp_err1), 32'd1);
      check_output("oor_inst", rsp_inst1, NOP);
      tick();
      check_output("oor_valid_idle", 32'(rsp_valid1), 32'd0);

      // Flush during WAIT.
      req_valid1 = 1'b1; req_addr1 = 32'h8;
      tick();
      req_valid1 = 1'b0; flush = 1'b1;
      #1 check_output("flw_ready", 32'(req_ready1), 32'd0);
      tick();
      flush = 1'b0;
      #1 check_output("flw_valid", 32'(rsp_valid1), 32'd0);
      check_output("flw_ready_idle", 32'(req_ready1), 32'd1);
      tick();
      check_output("flw_no_rsp", 32'(rsp_valid1), 32'd0);

      // Flush during RESP with a concurrent request.
      req_valid1 = 1'b1; req_addr1 = 32'h8; rsp_ready1 = 1'b0;
      tick();
      req_valid1 = 1'b0;
      tick();
      check_output("flr_valid_resp", 32'(rsp_valid1), 32'd1);
      check_output("flr_inst", rsp_inst1, I2);
      flush = 1'b1; rsp_ready1 = 1'b1; req_valid1 = 1'b1; req_addr1 = 32'h0;
      #1 check_output("flr_ready", 32'(req_ready1), 32'd0);
      tick();
      flush = 1'b0; req_valid1 = 1'b0;
      #1 check_output("flr_valid", 32'(rsp_valid1), 32'd0);
      check_output("flr_ready_idle", 32'(req_ready1), 32'd1);
      tick();
      tick();
      check_output("flr_no_rsp", 32'(rsp_valid1), 32'd0);

      // Asynchronous reset while in WAIT.
      req_valid1 = 1'b1; req_addr1 = 32'h0;
      tick();
      req_valid1 = 1'b0;
      #2 reset = 1'b1;
      #1;
      check_output("rst_valid", 32'(rsp_valid1), 32'd0);
      check_output("rst_inst", rsp_inst1, NOP);
      check_output("rst_err", 32'(rsp_err1), 32'd0);
      #1 reset = 1'b0;
      tick();
      tick();
      check_output("rst_no_rsp", 32'(rsp_valid1), 32'd0);

      // Back-to-back with zero wait states.
      req_valid0 = 1'b1; req_addr0 = 32'h0; rsp_ready0 = 1'b1;
      #1 check_output("b2b_ready0", 32'(req_ready0), 32'd1);
      tick();
      req_addr0 = 32'h4;
      #1 check_output("b2b_valid0", 32'(rsp_valid0), 32'd1);
      check_output("b2b_inst0", rsp_inst0, I0);
      check_output("b2b_ready1", 32'(req_ready0), 32'd1);
      tick();
      req_addr0 = 32'h8;
      #1 check_output("b2b_valid1", 32'(rsp_valid0), 32'd1);
      check_output("b2b_inst1", rsp_inst0, I1);
      check_output("b2b_ready2", 32'(req_ready0), 32'd1);
      tick();
      req_valid0 = 1'b0;
      #1 check_output("b2b_valid2", 32'(rsp_valid0), 32'd1);
      check_output("b2b_inst2", rsp_inst0, I2);
      check_output("b2b_err2", 32'(rsp_err0), 32'd0);
      tick();
      check_output("b2b_idle", 32'(rsp_valid0), 32'd0);

      // Read and write of the same word at the same edge returns old data.
      req_valid0 = 1'b1; req_addr0 = 32'h0;
      prog_we = 1'b1; prog_addr = 32'h0; prog_wdata = 32'h1234_5678;
      tick();
      prog_we = 1'b0; req_valid0 = 1'b0;
      #1 check_output("rbw_old", rsp_inst0, I0);
      tick();
      req_valid0 = 1'b1;
      tick();
      req_valid0 = 1'b0;
      #1 check_output("rbw_new", rsp_inst0, 32'h1234_5678);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
